// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC -> imem req/ready handshake -> small {pc,inst} FIFO for decode.
// Optional feature macro IFETCH_ALIGN_CHECK_EN turns misaligned PCs into flagged zero entries.
module ifetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              fetch_adv,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_misalign
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               mis_fetch;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  push_inst;

    logic [DATA_W-1:0]  inst_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [FIFO_DEPTH];

`ifdef IFETCH_ALIGN_CHECK_EN
    logic               mis_mem  [FIFO_DEPTH];

    // A misaligned PC completes without touching memory.
    assign mis_fetch     = (state == REQ) && (pc[1:0] != 2'b00);
    assign imem_addr     = pc;
    assign inst_misalign = inst_valid && mis_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mis_mem[wr_ptr] <= mis_fetch;
    end
`else
    assign mis_fetch     = 1'b0;
    assign imem_addr     = {pc[ADDR_W-1:2], 2'b00};
    assign inst_misalign = 1'b0;
`endif

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign fetch_adv  = push;
    assign push_inst  = mis_fetch ? '0 : imem_rdata;
    assign inst_out   = inst_valid ? inst_mem[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req = !mis_fetch;
                push     = (imem_req && imem_ready) || mis_fetch;
                if (push && (count == LAST_CNT) && !pop)
                    state_nxt = FULL;
            end
            FULL: begin
                if (pop)
                    state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
        // Redirect wins over everything, including a same-cycle memory ack.
        if (flush) begin
            push      = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= push_inst;
            pc_mem[wr_ptr]   <= pc;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(pop && (count == '0)));
            assert (!(push && (count == FULL_CNT)));
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by random traffic against a queue-based model.
module tb_ifetch_unit;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        fetch_adv;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_misalign;

    int checks = 0;
    int errors = 0;

    ifetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .flush(flush), .fetch_adv(fetch_adv),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_misalign(inst_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } ent_t;

    // Reference model: buffered entries, plus whether the unit is settling or blocked on a full buffer.
    ent_t        q[$];
    bit          m_idle;
    bit          m_stalled;
    logic [31:0] m_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000)
            return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_idle    = 1'b1;
        m_stalled = 1'b0;
        m_pc      = 32'h0000_3000;
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model, pass the rising edge.
    task automatic cycle(input bit fl, input logic [31:0] tgt, input bit rdy, input bit irdy);
        bit          active, mis, ereq, acc, evld, popped;
        logic [31:0] a;
        ent_t        e;
        a          = {m_pc[31:2], 2'b00};
        pc         = m_pc;
        flush      = fl;
        imem_ready = rdy;
        inst_ready = irdy;
        imem_rdata = mem_word(a);
        active = !m_idle && !m_stalled;
        mis    = ALIGN && active && (m_pc[1:0] != 2'b00);
        ereq   = active && !mis;
        acc    = !fl && ((ereq && rdy) || mis);
        evld   = (q.size() > 0);
        popped = evld && irdy;
        @(negedge clk);
        chk("imem_req", imem_req, ereq);
        if (ereq)
            chk("imem_addr", imem_addr, ALIGN ? m_pc : a);
        chk("fetch_adv", fetch_adv, acc);
        chk("inst_valid", inst_valid, evld);
        if (evld) begin
            chk("inst_out", inst_out, q[0].inst);
            chk("inst_pc", inst_pc, q[0].pc);
            chk("inst_misalign", inst_misalign, q[0].mis);
        end else begin
            chk("inst_out_empty", inst_out, 0);
            chk("inst_pc_empty", inst_pc, 0);
            chk("inst_misalign_empty", inst_misalign, 0);
        end
        if (fl) begin
            q.delete();
            m_idle    = 1'b1;
            m_stalled = 1'b0;
            m_pc      = tgt;
        end else begin
            if (popped)
                void'(q.pop_front());
            if (acc) begin
                e.pc   = m_pc;
                e.inst = mis ? 32'h0 : mem_word(a);
                e.mis  = mis;
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (m_idle)
                m_idle = 1'b0;
            else if (m_stalled)
                m_stalled = !popped;
            else if (acc && (q.size() == DEPTH))
                m_stalled = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        pc         = 32'h0000_3000;
        flush      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_fetch_adv", fetch_adv, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_out", inst_out, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_misalign", inst_misalign, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // First fetch after reset: one settling cycle, then request, then head valid.
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("t1_valid", inst_valid, 1);
        chk("t1_inst", inst_out, 32'h2008_0005);
        chk("t1_pc", inst_pc, 32'h0000_3000);

        // Buffer fills with decode stalled; one pop re-opens fetching at the next PC.
        cycle(0, 0, 1, 0);
        chk("t2_full_req", imem_req, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        chk("t2_rereq", imem_req, 1);
        chk("t2_rereq_addr", imem_addr, 32'h0000_3008);
        cycle(0, 0, 0, 1);

        // Three wait states: address held, no advance until ready.
        repeat (3) cycle(0, 0, 0, 0);
        chk("t3_addr_held", imem_addr, 32'h0000_3008);
        cycle(0, 0, 1, 0);

        // Flush coinciding with a memory ack while one entry is buffered.
        cycle(1, 32'h0000_3040, 1, 0);
        chk("t4_valid", inst_valid, 0);
        chk("t4_req_drop", imem_req, 0);
        cycle(0, 0, 1, 0);
        chk("t4_redirect_addr", imem_addr, 32'h0000_3040);

        // Streaming with simultaneous push and pop, wrapping the pointers.
        cycle(0, 0, 1, 0);
        repeat (16) cycle(0, 0, 1, 1);
        chk("t5_valid", inst_valid, 1);
        chk("t5_head_pc", inst_pc, 32'h0000_3080);

        // Misaligned PC handling.
        cycle(1, 32'h0000_3002, 0, 1);
        cycle(0, 0, 0, 0);
        if (ALIGN) begin
            chk("t6_req_off", imem_req, 0);
            cycle(0, 0, 0, 0);
            chk("t6_inst_zero", inst_out, 0);
            chk("t6_misalign", inst_misalign, 1);
        end else begin
            chk("t6_addr_aligned", imem_addr, 32'h0000_3000);
            cycle(0, 0, 1, 0);
            chk("t6_head_pc", inst_pc, 32'h0000_3002);
        end

        // Reset in the middle of a pending request abandons it.
        cycle(1, 32'h0000_3100, 0, 1);
        cycle(0, 0, 0, 0);
        reset      = 1'b1;
        imem_ready = 1'b1;
        #2;
        chk("t7_rst_req", imem_req, 0);
        chk("t7_rst_adv", fetch_adv, 0);
        chk("t7_rst_valid", inst_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Random traffic.
        repeat (400) begin
            logic [31:0] tgt;
            tgt = 32'h0000_3000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 7) == 0)
                tgt[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 19) == 0, tgt,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
